// File: rtl/mem_wb_stage_pkg.sv
// Shared types and sizes for the MEM/WB stage: FSM encoding, word/register widths, default data base.
package mem_wb_stage_pkg;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 4;
  localparam logic [WORD_W-1:0] BASE_ADDR_DEF = 32'd1024;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
endpackage

// File: rtl/mem_wb_stage_if.sv
// Request/response bus between the MEM/WB stage (master) and sram_mem (slave).
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic              mem_r_en_out;
  logic              mem_w_en_out;
  logic [WORD_W-1:0] mem_addr_out;
  logic [WORD_W-1:0] mem_wdata_out;
  logic              mem_ready_in;
  logic [WORD_W-1:0] mem_rdata_in;

  modport master (output mem_r_en_out, mem_w_en_out, mem_addr_out, mem_wdata_out,
                  input  mem_ready_in, mem_rdata_in);
  modport slave  (input  mem_r_en_out, mem_w_en_out, mem_addr_out, mem_wdata_out,
                  output mem_ready_in, mem_rdata_in);
endinterface

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register: reset > load > bubble > hold; load data is captured only on data_ld.
module mem_wb_reg
  import mem_wb_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  bubble,
  input  logic                  wb_en_d,
  input  logic                  rd_d,
  input  logic                  data_ld,
  input  logic [REG_ADDR_W-1:0] dest_d,
  input  logic [WORD_W-1:0]     alu_d,
  input  logic [WORD_W-1:0]     data_d,
  output logic                  wb_en_q,
  output logic                  rd_q,
  output logic [REG_ADDR_W-1:0] dest_q,
  output logic [WORD_W-1:0]     alu_q,
  output logic [WORD_W-1:0]     data_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q <= 1'b0;
      rd_q    <= 1'b0;
      dest_q  <= '0;
      alu_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      wb_en_q <= wb_en_d;
      rd_q    <= rd_d;
      dest_q  <= dest_d;
      alu_q   <= alu_d;
      if (data_ld) data_q <= data_d;
    end else if (bubble) begin
      // dest/alu hold; only the write-enables are squashed
      wb_en_q <= 1'b0;
      rd_q    <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: IDLE/BUSY handshake to sram_mem, freezes upstream while an access is pending.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  wb_en_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [WORD_W-1:0]     alu_res_in,
  input  logic [WORD_W-1:0]     value_rm_in,
  mem_wb_stage_if.master        mem,
  output logic                  freeze_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_wb_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [WORD_W-1:0]     alu_res_out,
  output logic [WORD_W-1:0]     mem_data_out
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  align_err_out
`endif
);
  state_e                state_q, state_d;
  logic                  req, acc_req, misal;
  logic [WORD_W-1:0]     addr_calc;
  logic                  lat_wb_en;
  logic [REG_ADDR_W-1:0] lat_dest;
  logic [WORD_W-1:0]     lat_alu;
  logic                  wb_load, wb_bubble, wb_wb_en, wb_rd, wb_data_ld;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [WORD_W-1:0]     wb_alu;

  assign req       = mem_r_en_in | mem_w_en_in;
  assign addr_calc = alu_res_in - BASE_ADDR;
`ifdef MEM_ALIGN_CHECK_EN
  assign misal     = req & (addr_calc[1:0] != 2'b00);
`else
  assign misal     = 1'b0;
`endif
  assign acc_req   = req & ~misal;

  always_comb begin
    state_d    = state_q;
    freeze_out = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    wb_wb_en   = wb_en_in;
    wb_rd      = 1'b0;
    wb_data_ld = 1'b0;
    wb_dest    = dest_in;
    wb_alu     = alu_res_in;
    case (state_q)
      IDLE: begin
        if (acc_req) begin
          state_d    = BUSY;
          freeze_out = 1'b1;
          wb_bubble  = 1'b1;
        end else if (misal) begin
          wb_bubble  = 1'b1;
        end else begin
          wb_load    = 1'b1;
        end
      end
      BUSY: begin
        if (mem.mem_ready_in) begin
          // the registered read enable doubles as the latched read flag
          state_d    = IDLE;
          wb_load    = 1'b1;
          wb_wb_en   = lat_wb_en;
          wb_dest    = lat_dest;
          wb_alu     = lat_alu;
          wb_rd      = mem.mem_r_en_out;
          wb_data_ld = mem.mem_r_en_out;
        end else begin
          freeze_out = 1'b1;
          wb_bubble  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      lat_wb_en         <= 1'b0;
      lat_dest          <= '0;
      lat_alu           <= '0;
      mem.mem_r_en_out  <= 1'b0;
      mem.mem_w_en_out  <= 1'b0;
      mem.mem_addr_out  <= '0;
      mem.mem_wdata_out <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && acc_req) begin
        lat_wb_en         <= wb_en_in;
        lat_dest          <= dest_in;
        lat_alu           <= alu_res_in;
        // a write wins when both enables are set
        mem.mem_r_en_out  <= mem_r_en_in & ~mem_w_en_in;
        mem.mem_w_en_out  <= mem_w_en_in;
        mem.mem_addr_out  <= addr_calc;
        mem.mem_wdata_out <= value_rm_in;
      end else if (state_q == BUSY && mem.mem_ready_in) begin
        mem.mem_r_en_out  <= 1'b0;
        mem.mem_w_en_out  <= 1'b0;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) align_err_out <= 1'b0;
    else     align_err_out <= (state_q == IDLE) & misal;
  end
`endif

  mem_wb_reg u_wb_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (wb_load),
    .bubble  (wb_bubble),
    .wb_en_d (wb_wb_en),
    .rd_d    (wb_rd),
    .data_ld (wb_data_ld),
    .dest_d  (wb_dest),
    .alu_d   (wb_alu),
    .data_d  (mem.mem_rdata_in),
    .wb_en_q (wb_en_out),
    .rd_q    (mem_r_en_wb_out),
    .dest_q  (dest_out),
    .alu_q   (alu_res_out),
    .data_q  (mem_data_out)
  );
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; the bench plays sram_mem through the interface.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        r_en, w_en, wb_en;
  logic [3:0]  dest;
  logic [31:0] alu, vrm;
  logic        freeze, wb_en_o, r_wb_o;
  logic [3:0]  dest_o;
  logic [31:0] alu_o, data_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif
  int n_cmp = 0;
  int n_err = 0;
  int fz_cnt, we_cnt;

  mem_wb_stage_if bus();

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .mem_r_en_in(r_en), .mem_w_en_in(w_en), .wb_en_in(wb_en),
    .dest_in(dest), .alu_res_in(alu), .value_rm_in(vrm),
    .mem(bus),
    .freeze_out(freeze), .wb_en_out(wb_en_o), .mem_r_en_wb_out(r_wb_o),
    .dest_out(dest_o), .alu_res_out(alu_o), .mem_data_out(data_o)
`ifdef MEM_ALIGN_CHECK_EN
    , .align_err_out(align_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    r_en = 0; w_en = 0; wb_en = 0; dest = 0; alu = 0; vrm = 0;
    bus.mem_ready_in = 0; bus.mem_rdata_in = 0;
  endtask

  initial begin
    idle_in();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_wb_en", 32'(wb_en_o), 0);
    chk("rst_r_wb", 32'(r_wb_o), 0);
    chk("rst_dest", 32'(dest_o), 0);
    chk("rst_alu", alu_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_r_en", 32'(bus.mem_r_en_out), 0);
    chk("rst_w_en", 32'(bus.mem_w_en_out), 0);
    chk("rst_addr", bus.mem_addr_out, 0);
    chk("rst_freeze", 32'(freeze), 0);

    // ready/rdata must be ignored in IDLE
    bus.mem_ready_in = 1; bus.mem_rdata_in = 32'hFFFF_FFFF;
    tick(); idle_in();
    chk("idle_ready_data", data_o, 0);
    chk("idle_ready_rwb", 32'(r_wb_o), 0);

    // load hit: ready in first BUSY cycle
    r_en = 1; wb_en = 1; dest = 5; alu = 1028; #1;
    chk("ld_freeze_req", 32'(freeze), 1);
    tick();
    chk("ld_r_en", 32'(bus.mem_r_en_out), 1);
    chk("ld_w_en", 32'(bus.mem_w_en_out), 0);
    chk("ld_addr", bus.mem_addr_out, 4);
    chk("ld_bubble_wb", 32'(wb_en_o), 0);
    bus.mem_ready_in = 1; bus.mem_rdata_in = 32'hDEAD_BEEF; #1;
    chk("ld_freeze_busy", 32'(freeze), 0);
    tick(); idle_in(); #1;
    chk("ld_data", data_o, 32'hDEAD_BEEF);
    chk("ld_wb_en", 32'(wb_en_o), 1);
    chk("ld_rwb", 32'(r_wb_o), 1);
    chk("ld_dest", 32'(dest_o), 5);
    chk("ld_alu", alu_o, 1028);
    chk("ld_r_en_drop", 32'(bus.mem_r_en_out), 0);
    chk("ld_freeze_done", 32'(freeze), 0);
    tick();

    // store miss: ready on the 5th BUSY cycle
    w_en = 1; dest = 2; alu = 1040; vrm = 32'h1234_5678; #1;
    fz_cnt = freeze ? 1 : 0;
    we_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (bus.mem_w_en_out) we_cnt++;
      chk("st_wdata", bus.mem_wdata_out, 32'h1234_5678);
      chk("st_addr", bus.mem_addr_out, 16);
      chk("st_wb_bubble", 32'(wb_en_o), 0);
      bus.mem_ready_in = (k == 5); bus.mem_rdata_in = 32'h0BAD_0BAD; #1;
      if (freeze) fz_cnt++;
    end
    tick(); idle_in(); #1;
    chk("st_freeze_cycles", 32'(fz_cnt), 5);
    chk("st_w_en_cycles", 32'(we_cnt), 5);
    chk("st_w_en_drop", 32'(bus.mem_w_en_out), 0);
    chk("st_rwb", 32'(r_wb_o), 0);
    chk("st_data_hold", data_o, 32'hDEAD_BEEF);
    chk("st_dest", 32'(dest_o), 2);
    chk("st_alu", alu_o, 1040);

    // non-memory stream: WB follows inputs one cycle later
    for (int i = 0; i < 4; i++) begin
      wb_en = 1; dest = 3; alu = 7 + i; #1;
      chk("nm_freeze", 32'(freeze), 0);
      tick();
      chk("nm_wb_en", 32'(wb_en_o), 1);
      chk("nm_dest", 32'(dest_o), 3);
      chk("nm_alu", alu_o, 32'(7 + i));
      chk("nm_rwb", 32'(r_wb_o), 0);
    end
    idle_in();

    // both enables: write wins
    r_en = 1; w_en = 1; alu = 1032; vrm = 32'hAABB_CCDD;
    tick();
    chk("both_w_en", 32'(bus.mem_w_en_out), 1);
    chk("both_r_en", 32'(bus.mem_r_en_out), 0);
    chk("both_addr", bus.mem_addr_out, 8);
    bus.mem_ready_in = 1; bus.mem_rdata_in = 32'h1111_1111;
    tick(); idle_in(); #1;
    chk("both_rwb", 32'(r_wb_o), 0);
    chk("both_data_hold", data_o, 32'hDEAD_BEEF);

    // back-to-back reads, second accepted right after completion
    r_en = 1; wb_en = 1; dest = 1; alu = 1036;
    tick();
    bus.mem_ready_in = 1; bus.mem_rdata_in = 32'hCAFE_0001;
    tick();
    bus.mem_ready_in = 0; dest = 4; alu = 1044; #1;
    chk("b2b_data1", data_o, 32'hCAFE_0001);
    chk("b2b_dest1", 32'(dest_o), 1);
    chk("b2b_freeze2", 32'(freeze), 1);
    tick();
    chk("b2b_addr2", bus.mem_addr_out, 20);
    chk("b2b_r_en2", 32'(bus.mem_r_en_out), 1);
    bus.mem_ready_in = 1; bus.mem_rdata_in = 32'hCAFE_0002;
    tick(); idle_in(); #1;
    chk("b2b_data2", data_o, 32'hCAFE_0002);
    chk("b2b_dest2", 32'(dest_o), 4);

    // reset during a pending read, with ready coinciding
    r_en = 1; wb_en = 1; dest = 9; alu = 1100;
    tick();
    tick();
    rst = 1; bus.mem_ready_in = 1; bus.mem_rdata_in = 32'h5555_5555;
    tick();
    rst = 0; idle_in(); #1;
    chk("rb_wb_en", 32'(wb_en_o), 0);
    chk("rb_rwb", 32'(r_wb_o), 0);
    chk("rb_dest", 32'(dest_o), 0);
    chk("rb_alu", alu_o, 0);
    chk("rb_data", data_o, 0);
    chk("rb_r_en", 32'(bus.mem_r_en_out), 0);
    chk("rb_addr", bus.mem_addr_out, 0);
    chk("rb_freeze", 32'(freeze), 0);

`ifdef MEM_ALIGN_CHECK_EN
    r_en = 1; wb_en = 1; dest = 6; alu = 1026; #1;
    chk("al_freeze", 32'(freeze), 0);
    tick(); idle_in(); #1;
    chk("al_err", 32'(align_err), 1);
    chk("al_r_en", 32'(bus.mem_r_en_out), 0);
    chk("al_wb_en", 32'(wb_en_o), 0);
    chk("al_rwb", 32'(r_wb_o), 0);
    tick();
    chk("al_err_drop", 32'(align_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter BASE_ADDR, default 32'd1024: data-segment base subtracted from the ALU result to form the memory address.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_r_en_in, mem_w_en_in  in  1 each  load/store request from EXE/MEM register.
REQ-005 wb_en_in  in  1; dest_in  in  4; alu_res_in  in  32; value_rm_in  in  32  instruction payload.
REQ-006 mem_r_en_out, mem_w_en_out  out  1 each  request to sram_mem.
REQ-007 mem_addr_out  out  32; mem_wdata_out  out  32  address and store data to sram_mem.
REQ-008 mem_ready_in  in  1; mem_rdata_in  in  32  completion strobe and load data from sram_mem.
REQ-009 freeze_out  out  1  stalls all upstream pipeline registers and the PC.
REQ-010 wb_en_out, mem_r_en_wb_out  out  1; dest_out  out  4; alu_res_out, mem_data_out  out  32  MEM/WB register contents.
REQ-011 align_err_out  out  1  misaligned-access flag; exists only with MEM_ALIGN_CHECK_EN.

Function
REQ-012 FSM states IDLE and BUSY shall be implemented.
REQ-013 IDLE, no request: the WB register loads all payload inputs every cycle, mem_r_en_wb_out=0, mem_data_out holds, and the state stays IDLE.
REQ-014 IDLE, request present: latch the payload, the address (alu_res_in - BASE_ADDR, modulo 2^32) and value_rm_in, then go to BUSY.
REQ-015 When both enables are high, the request is a write, and the read shall be ignored.
REQ-016 Request outputs are registered and high only in BUSY; mem_addr_out and mem_wdata_out are stable throughout BUSY.
REQ-017 freeze_out = (IDLE and request present) or (BUSY and not mem_ready_in), and is combinational.
REQ-018 While frozen, wb_en_out=0 and mem_r_en_wb_out=0 (bubble), so WB never writes twice.
REQ-019 BUSY with mem_ready_in=1: load the latched payload into the WB register, set mem_r_en_wb_out to the latched read flag, capture mem_data_out=mem_rdata_in on reads (hold on writes), drop the request outputs, and return to IDLE.
REQ-020 Minimum access latency is 2 cycles, request to WB-register valid, when ready arrives in the first BUSY cycle; there is no upper bound and no timeout.
REQ-021 mem_ready_in and mem_rdata_in shall be ignored in IDLE.
REQ-022 Back-to-back requests: the second request is accepted in the IDLE cycle after completion; no idle gap is required upstream.

Reset
REQ-023 rst forces IDLE, and drives all outputs and latches to 0 at the next edge.
REQ-024 rst overrides a concurrent mem_ready_in.
REQ-025 Reset mid-BUSY abandons the access without a WB write; sram_mem is reset by the same rst.

Configuration
REQ-026 With MEM_ALIGN_CHECK_EN defined, an IDLE request whose computed address[1:0]!=0 shall not enter BUSY and shall not assert freeze_out.
REQ-027 In that case it completes in one cycle with wb_en_out=0 and mem_r_en_wb_out=0, and align_err_out pulses high for exactly that cycle.
REQ-028 Without MEM_ALIGN_CHECK_EN, align_err_out and its check are absent, and the address is passed unchecked.

Structure
REQ-029 A shared package shall hold the state encoding (IDLE=0, BUSY=1), BASE_ADDR default, REG_ADDR_W=4 and WORD_W=32.
REQ-030 One sub-module, mem_wb_reg, shall implement the MEM/WB register with load, bubble and reset controls; the FSM stays in mem_wb_stage.

Verification
REQ-031 Load hit: rd_en, alu_res=1028, ready in first BUSY cycle, rdata=0xDEADBEEF -> mem_addr_out=4, freeze high 1 cycle, next cycle mem_data_out=0xDEADBEEF, wb_en_out=1.
REQ-032 Store miss: wr_en, value_rm=0x12345678, ready after 5 BUSY cycles -> mem_w_en_out high 5 cycles, wdata stable, freeze high 5 cycles, then WB register loads, mem_r_en_wb_out=0.
REQ-033 Non-memory stream: wb_en=1, dest=3, alu_res=7 each cycle -> freeze_out=0, WB outputs follow inputs with 1-cycle latency.
REQ-034 Reset in BUSY: rst asserted on cycle 2 of a pending read -> next cycle IDLE, all outputs 0, no WB write even if ready coincides.
REQ-035 Both enables high, alu_res=1032 -> write issued to address 8, mem_r_en_out stays 0.
REQ-036 Macro defined, rd_en, alu_res=1026 -> align_err_out one-cycle pulse, no request, freeze_out=0, wb_en_out=0.
